haar_dwt_cascade: RTL and testbench

- Multi-level Haar wavelet decomposition stage. It sits directly downstream of the ADC sample/injection stage.
- It consumes the sample pair x[n], x[n-1] and that stage's registered valid strobe.
- It produces decimated approximation and detail coefficients for LEVELS octaves.
- Outputs feed the band-select/DAC output mux and the per-level recording logic.

---
 rtl/haar_dwt_cascade_pkg.sv | 32 +++
 rtl/haar_dwt_cascade_if.sv | 33 +++
 rtl/haar_dwt_cascade_level.sv | 73 +++++++
 rtl/haar_dwt_cascade.sv | 76 +++++++
 tb/tb_haar_dwt_cascade.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/haar_dwt_cascade_pkg.sv
// -----------------------------------------------------------------------------
// haar_dwt_cascade_pkg
//   Shared constants and the Haar butterfly used by every cascade level.
//   - DEFAULT_ADC_WIDTH : default sample/coefficient width
//   - MAX_LEVELS        : deepest supported cascade
//   - haar_pair()       : returns {a, d} for an (earlier, later) operand pair
// -----------------------------------------------------------------------------
package haar_dwt_cascade_pkg;

    localparam int DEFAULT_ADC_WIDTH = 14;
    localparam int MAX_LEVELS        = 4;

    // Working width of the butterfly. Operands are sign-extended into it, so
    // the sum/difference is exact for any ADC_WIDTH up to 30 bits; the low
    // ADC_WIDTH bits after the shift equal the ADC_WIDTH+1-bit result.
    localparam int CALC_W = 32;

    typedef struct packed {
        logic signed [CALC_W-1:0] a;
        logic signed [CALC_W-1:0] d;
    } haar_pair_t;

    // Arithmetic shift gives floor rounding (toward -inf).
    function automatic haar_pair_t haar_pair(input logic signed [CALC_W-1:0] e,
                                             input logic signed [CALC_W-1:0] o);
        haar_pair_t r;
        r.a = (e + o) >>> 1;
        r.d = (e - o) >>> 1;
        return r;
    endfunction

endpackage

// File: rtl/haar_dwt_cascade_if.sv
// -----------------------------------------------------------------------------
// haar_dwt_cascade_if
//   Sample input and coefficient output bundle of the Haar cascade.
//   master : upstream/consumer side (drives samples and controls)
//   slave  : the cascade itself (drives coefficients, strobes, pair count)
// -----------------------------------------------------------------------------
interface haar_dwt_cascade_if
    import haar_dwt_cascade_pkg::*;
#(
    parameter int ADC_WIDTH = DEFAULT_ADC_WIDTH,
    parameter int LEVELS    = 3
);
    logic signed [ADC_WIDTH-1:0]        x_0;
    logic signed [ADC_WIDTH-1:0]        x_1;
    logic                               in_valid;
    logic                               en;
    logic                               sync_clr;
    logic        [LEVELS*ADC_WIDTH-1:0] detail_out;
    logic        [LEVELS-1:0]           detail_valid;
    logic signed [ADC_WIDTH-1:0]        approx_out;
    logic                               approx_valid;
    logic        [15:0]                 pair_cnt;

    modport master (
        output x_0, x_1, in_valid, en, sync_clr,
        input  detail_out, detail_valid, approx_out, approx_valid, pair_cnt
    );

    modport slave (
        input  x_0, x_1, in_valid, en, sync_clr,
        output detail_out, detail_valid, approx_out, approx_valid, pair_cnt
    );
endinterface

// File: rtl/haar_dwt_cascade_level.sv
// -----------------------------------------------------------------------------
// haar_level
//   One Haar octave: phase bit, hold register and registered a/d outputs.
//   FIRST=1 : operands come directly from in_e (x[n-1]) / in_o (x[n]) and
//             every second accepted input completes a pair.
//   FIRST=0 : in_o is the previous level's approximation; the first of each
//             pair is parked in hold, the second completes the pair.
// Ports
//   clk, rst_n        clock / async active-low reset
//   sync_clr          clears phase and drops the incoming strobe
//   in_valid          input strobe (already qualified by en for level 1)
//   in_e, in_o        earlier / later operand
//   fire              combinational: this cycle completes a pair
//   a_out, d_out      registered coefficients, held between strobes
//   valid_out         one-cycle result strobe
// -----------------------------------------------------------------------------
module haar_level
    import haar_dwt_cascade_pkg::*;
#(
    parameter int ADC_WIDTH = DEFAULT_ADC_WIDTH,
    parameter bit FIRST     = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sync_clr,
    input  logic                        in_valid,
    input  logic signed [ADC_WIDTH-1:0] in_e,
    input  logic signed [ADC_WIDTH-1:0] in_o,
    output logic                        fire,
    output logic signed [ADC_WIDTH-1:0] a_out,
    output logic signed [ADC_WIDTH-1:0] d_out,
    output logic                        valid_out
);
    logic                        phase;
    logic                        accept;
    logic signed [ADC_WIDTH-1:0] hold;
    logic signed [ADC_WIDTH-1:0] e_sel;
    haar_pair_t                  res;

    // NOTE: every always_comb output gets a value on every path, so no latch.
    always_comb begin
        accept = in_valid & ~sync_clr;
        fire   = accept & phase;
        e_sel  = FIRST ? in_e : hold;
        res    = haar_pair(CALC_W'(e_sel), CALC_W'(in_o));
    end

    // NOTE: non-blocking assignments so all levels update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= 1'b0;
            hold      <= '0;
            a_out     <= '0;
            d_out     <= '0;
            valid_out <= 1'b0;
        end else begin
            // sync_clr forces accept low, so in-flight strobes die here too.
            valid_out <= fire;
            if (sync_clr) begin
                phase <= 1'b0;
            end else if (accept) begin
                phase <= ~phase;
            end
            if (!FIRST && accept && !phase) begin
                hold <= in_o;
            end
            if (fire) begin
                a_out <= res.a[ADC_WIDTH-1:0];
                d_out <= res.d[ADC_WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/haar_dwt_cascade.sv
// -----------------------------------------------------------------------------
// haar_dwt_cascade
//   LEVELS-deep Haar wavelet decomposition of the ADC sample stream. Level 1
//   pairs x[n-1]/x[n]; each deeper level pairs the previous approximation,
//   one register stage per level.
// Ports
//   clk, rst_n   clock / async active-low reset
//   bus (slave)  x_0, x_1, in_valid, en, sync_clr in;
//                detail_out, detail_valid, approx_out, approx_valid,
//                pair_cnt out
//   LEVELS must lie in 1..MAX_LEVELS.
// -----------------------------------------------------------------------------
module haar_dwt_cascade
    import haar_dwt_cascade_pkg::*;
#(
    parameter int ADC_WIDTH = DEFAULT_ADC_WIDTH,
    parameter int LEVELS    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    haar_dwt_cascade_if.slave  bus
);
    logic signed [ADC_WIDTH-1:0]        a_lvl [LEVELS];
    logic signed [ADC_WIDTH-1:0]        d_lvl [LEVELS];
    logic        [LEVELS-1:0]           v_lvl;
    logic        [LEVELS-1:0]           fire_lvl;
    logic        [LEVELS*ADC_WIDTH-1:0] detail_pk;
    logic        [15:0]                 pair_cnt_q;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        if (k == 0) begin : g_first
            // en gates only new level-1 acceptance; deeper levels keep draining.
            haar_level #(.ADC_WIDTH(ADC_WIDTH), .FIRST(1'b1)) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .sync_clr  (bus.sync_clr),
                .in_valid  (bus.in_valid & bus.en),
                .in_e      (bus.x_1),
                .in_o      (bus.x_0),
                .fire      (fire_lvl[k]),
                .a_out     (a_lvl[k]),
                .d_out     (d_lvl[k]),
                .valid_out (v_lvl[k])
            );
        end else begin : g_next
            haar_level #(.ADC_WIDTH(ADC_WIDTH), .FIRST(1'b0)) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .sync_clr  (bus.sync_clr),
                .in_valid  (v_lvl[k-1]),
                .in_e      (a_lvl[k-1]),
                .in_o      (a_lvl[k-1]),
                .fire      (fire_lvl[k]),
                .a_out     (a_lvl[k]),
                .d_out     (d_lvl[k]),
                .valid_out (v_lvl[k])
            );
        end
        assign detail_pk[k*ADC_WIDTH +: ADC_WIDTH] = d_lvl[k];
    end

    // Counts completed level-1 pairs on the same edge their result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt_q <= '0;
        end else if (fire_lvl[0]) begin
            pair_cnt_q <= pair_cnt_q + 16'd1;
        end
    end

    assign bus.detail_out   = detail_pk;
    assign bus.detail_valid = v_lvl;
    assign bus.approx_out   = a_lvl[LEVELS-1];
    assign bus.approx_valid = v_lvl[LEVELS-1];
    assign bus.pair_cnt     = pair_cnt_q;
endmodule

// File: tb/tb_haar_dwt_cascade.sv
// -----------------------------------------------------------------------------
// tb_haar_dwt_cascade
//   Directed bench for haar_dwt_cascade. A LEVELS=3 instance is the main DUT;
//   a LEVELS=1 instance fed the same stream exposes the level-1 approximation.
// -----------------------------------------------------------------------------
module tb_haar_dwt_cascade;
    localparam int W = 14;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    haar_dwt_cascade_if #(.ADC_WIDTH(W), .LEVELS(3)) bus ();
    haar_dwt_cascade_if #(.ADC_WIDTH(W), .LEVELS(1)) bus1 ();

    assign bus1.x_0      = bus.x_0;
    assign bus1.x_1      = bus.x_1;
    assign bus1.in_valid = bus.in_valid;
    assign bus1.en       = bus.en;
    assign bus1.sync_clr = bus.sync_clr;

    haar_dwt_cascade #(.ADC_WIDTH(W), .LEVELS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    haar_dwt_cascade #(.ADC_WIDTH(W), .LEVELS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int det(input int k);
        logic [W-1:0] t;
        t = bus.detail_out[k*W +: W];
        return sx(t);
    endfunction

    // Present one input for one edge, then look #1 after that edge.
    task automatic step(input logic v, input int xn, input int xp, input logic clr = 1'b0);
        bus.in_valid = v;
        bus.x_0      = W'(xn);
        bus.x_1      = W'(xp);
        bus.sync_clr = clr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.sync_clr = 1'b0;
    endtask

    task automatic clear_phases();
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
    endtask

    // Ramp 10..80, x_1 = previous sample; strobe pattern per edge.
    task automatic run_ramp(input int n_edges);
        int exp_v [10] = '{0, 1, 0, 1, 2, 1, 0, 1, 2, 4};
        int l1_idx = 0;
        for (int i = 0; i < n_edges; i++) begin
            if (i < 8) step(1'b1, 10 * (i + 1), 10 * i);
            else       step(1'b0, 0, 0);
            check($sformatf("ramp_valid_e%0d", i + 1), bus.detail_valid, exp_v[i]);
            if (exp_v[i] == 1) begin
                check("ramp_l1_a", sx(bus1.approx_out), 15 + 20 * l1_idx);
                check("ramp_l1_d", det(0), -5);
                l1_idx++;
            end
            if (exp_v[i] == 2) check("ramp_l2_d", det(1), -10);
            if (exp_v[i] == 4) begin
                check("ramp_l3_d", det(2), -20);
                check("ramp_approx", sx(bus.approx_out), 45);
                check("ramp_approx_valid", bus.approx_valid, 1);
            end
        end
    endtask

    task automatic pair_l1(input string tag, input int e, input int o,
                           input int exp_a, input int exp_d);
        step(1'b1, 0, 0);
        step(1'b1, o, e);
        check({tag, "_valid"}, bus1.detail_valid, 1);
        check({tag, "_a"}, sx(bus1.approx_out), exp_a);
        check({tag, "_d"}, sx(bus1.detail_out), exp_d);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_detail"}, bus.detail_out, 0);
        check({tag, "_valid"}, bus.detail_valid, 0);
        check({tag, "_approx"}, bus.approx_out, 0);
        check({tag, "_avalid"}, bus.approx_valid, 0);
        check({tag, "_cnt"}, bus.pair_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        bus.x_0      = '0;
        bus.x_1      = '0;
        bus.in_valid = 1'b0;
        bus.en       = 1'b1;
        bus.sync_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step(1'b0, 0, 0);

        // Ramp through all three levels.
        run_ramp(10);
        check("ramp_cnt", bus.pair_cnt, 4);

        // Extremes and rounding at level 1.
        clear_phases();
        pair_l1("ext_pp", 8191, 8191, 8191, 0);
        pair_l1("ext_nn", -8192, -8192, -8192, 0);
        pair_l1("ext_pn", 8191, -8192, -1, 8191);
        pair_l1("ext_np", -8192, 8191, -1, -8192);
        pair_l1("rnd_neg", -7, -8, -8, 0);
        pair_l1("rnd_pos", 3, 0, 1, 1);
        check("ext_cnt", bus.pair_cnt, 10);

        // sync_clr arriving with the 4th input while phase1=1.
        clear_phases();
        step(1'b1, 1, 0);
        step(1'b1, 2, 1);
        step(1'b1, 3, 2);
        step(1'b1, 4, 3, 1'b1);
        check("clr_after4_valid", bus.detail_valid, 0);
        step(1'b1, 50, 4);
        check("clr_after5_valid", bus.detail_valid, 0);
        step(1'b1, 60, 50);
        check("clr_after6_valid", bus.detail_valid, 1);
        check("clr_pair_a", sx(bus1.approx_out), 55);
        check("clr_pair_d", det(0), -5);
        check("clr_cnt", bus.pair_cnt, 12);
        step(1'b0, 0, 0);
        check("clr_idle_valid", bus.detail_valid, 0);

        // en=0 while in_valid pulses; phase must survive.
        clear_phases();
        step(1'b1, 100, 90);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 7 * i + 1, 7 * i);
            check($sformatf("en_off_valid%0d", i), bus.detail_valid, 0);
        end
        check("en_off_cnt", bus.pair_cnt, 12);
        bus.en = 1'b1;
        step(1'b1, 200, 100);
        check("en_on_valid", bus1.detail_valid, 1);
        check("en_on_a", sx(bus1.approx_out), 150);
        check("en_on_d", det(0), -50);
        check("en_on_cnt", bus.pair_cnt, 13);

        // Reset while L2/L3 are in flight, then replay the ramp.
        clear_phases();
        run_ramp(9);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 0);
            check($sformatf("midrst_hold_valid%0d", i), bus.detail_valid, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 0, 0);
            check($sformatf("postrst_valid%0d", i), bus.detail_valid, 0);
        end
        run_ramp(10);
        check("replay_cnt", bus.pair_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
